rename_register_file: RTL and testbench

Multi-issue successor to the single-decode register file. Holds architectural values plus a busy/ROB-tag rename table, serves DEC_WIDTH decode slots (two sources each) with in-group and commit bypass, and retires COMMIT_WIDTH ROB entries per cycle. It also keeps CKPT_CNT snapshots of the rename table, so a mispredicted branch restores state selectively instead of clearing every dependency. It sits between the decoder/dispatch stage and the ROB commit port.

---
 rtl/rename_register_file_pkg.sv | 22 ++
 rtl/rename_register_file_ckpt_bank.sv | 99 +++++++++
 rtl/rename_register_file.sv | 191 +++++++++++++++++++
 tb/tb_rename_register_file.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_register_file_pkg.sv
// Shared sizes and types for the rename register file.
// Imported by the top module, the checkpoint bank and the bench.
package rename_register_file_pkg;

    localparam int XLEN           = 32;
    localparam int REG_CNT_WIDTH  = 5;
    localparam int REG_CNT        = 2 ** REG_CNT_WIDTH;
    localparam int ROB_SIZE_WIDTH = 4;
    localparam int DEC_WIDTH      = 2;
    localparam int COMMIT_WIDTH   = 2;
    localparam int CKPT_CNT       = 4;
    localparam int CKPT_WIDTH     = $clog2(CKPT_CNT);
    localparam int LANE_WIDTH     =
        (DEC_WIDTH > 1) ? $clog2(DEC_WIDTH) : 1;

    typedef logic [REG_CNT_WIDTH-1:0]  reg_idx_t;
    typedef logic [ROB_SIZE_WIDTH-1:0] rob_tag_t;
    typedef logic [CKPT_WIDTH-1:0]     ckpt_idx_t;
    typedef logic [REG_CNT-1:0]        busy_vec_t;
    typedef rob_tag_t [REG_CNT-1:0]    tag_tab_t;

endpackage

// File: rtl/rename_register_file_ckpt_bank.sv
// Checkpoint storage: circular FIFO of rename-table snapshots.
// Ports: snapshot write data, restore data for recover_id,
// commit broadcast that clears matching busy bits, ckpt_id/ckpt_full.
module rf_ckpt_bank
    import rename_register_file_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  rdy,
    input  logic                                  flush,
    input  logic                                  stall,
    input  logic                                  ckpt_req,
    input  logic                                  ckpt_release,
    input  logic                                  recover,
    input  ckpt_idx_t                             recover_id,
    input  logic [COMMIT_WIDTH-1:0]               cmt_valid,
    input  logic [COMMIT_WIDTH*REG_CNT_WIDTH-1:0] cmt_rd,
    input  logic [COMMIT_WIDTH*ROB_SIZE_WIDTH-1:0] cmt_tag,
    input  busy_vec_t                             snap_busy,
    input  tag_tab_t                              snap_tag,
    output busy_vec_t                             rec_busy,
    output tag_tab_t                              rec_tag,
    output ckpt_idx_t                             ckpt_id,
    output logic                                  ckpt_full
);

    busy_vec_t [CKPT_CNT-1:0] sbusy;
    busy_vec_t [CKPT_CNT-1:0] sbusy_nx;
    tag_tab_t  [CKPT_CNT-1:0] stag;
    ckpt_idx_t                head;
    ckpt_idx_t                tail;
    logic [CKPT_WIDTH:0]      count;
    logic                     alloc;
    logic                     rel;

    assign ckpt_full = (count == (CKPT_WIDTH+1)'(CKPT_CNT));
    assign ckpt_id   = tail;

    // A pop in the same cycle frees the slot the push needs,
    // so a full FIFO still accepts a request paired with a release.
    assign rel   = ckpt_release & (count != '0);
    assign alloc = ckpt_req & ~stall & ~flush & ~recover
                 & (~ckpt_full | rel);

    // Commit broadcast: a retiring producer clears its busy bit
    // in every snapshot that still names it.
    always_comb begin
        sbusy_nx = sbusy;
        for (int k = 0; k < CKPT_CNT; k++) begin
            for (int r = 1; r < REG_CNT; r++) begin
                for (int l = 0; l < COMMIT_WIDTH; l++) begin
                    if (cmt_valid[l]
                        && cmt_rd[l*REG_CNT_WIDTH +: REG_CNT_WIDTH]
                           == REG_CNT_WIDTH'(r)
                        && cmt_tag[l*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH]
                           == stag[k][r]) begin
                        sbusy_nx[k][r] = 1'b0;
                    end
                end
            end
        end
    end

    assign rec_busy = sbusy_nx[recover_id];
    assign rec_tag  = stag[recover_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbusy <= '0;
            stag  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            sbusy <= sbusy_nx;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (recover) begin
                // Restored slot and everything younger are freed.
                tail  <= recover_id;
                count <= {1'b0, CKPT_WIDTH'(recover_id - head)};
            end else begin
                if (alloc) begin
                    sbusy[tail] <= snap_busy;
                    stag[tail]  <= snap_tag;
                    tail        <= tail + 1'b1;
                end
                if (rel) begin
                    head <= head + 1'b1;
                end
                count <= count + (CKPT_WIDTH+1)'(alloc)
                               - (CKPT_WIDTH+1)'(rel);
            end
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Multi-issue register file with busy/ROB-tag rename table.
// Ports: decode slots (sources out), commit lanes, checkpoint control.
module rename_register_file
    import rename_register_file_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   rdy,
    input  logic                                   flush,
    input  logic                                   stall,
    input  logic [DEC_WIDTH-1:0]                   dec_valid,
    input  logic [DEC_WIDTH-1:0]                   dec_wr,
    input  logic [DEC_WIDTH*REG_CNT_WIDTH-1:0]     dec_rd,
    input  logic [DEC_WIDTH*REG_CNT_WIDTH-1:0]     dec_rs1,
    input  logic [DEC_WIDTH*REG_CNT_WIDTH-1:0]     dec_rs2,
    input  logic [DEC_WIDTH*ROB_SIZE_WIDTH-1:0]    dec_tag,
    output logic [DEC_WIDTH*XLEN-1:0]              rf_val1,
    output logic [DEC_WIDTH*XLEN-1:0]              rf_val2,
    output logic [DEC_WIDTH-1:0]                   rf_busy1,
    output logic [DEC_WIDTH-1:0]                   rf_busy2,
    output logic [DEC_WIDTH*ROB_SIZE_WIDTH-1:0]    rf_tag1,
    output logic [DEC_WIDTH*ROB_SIZE_WIDTH-1:0]    rf_tag2,
    input  logic [COMMIT_WIDTH-1:0]                cmt_valid,
    input  logic [COMMIT_WIDTH*REG_CNT_WIDTH-1:0]  cmt_rd,
    input  logic [COMMIT_WIDTH*ROB_SIZE_WIDTH-1:0] cmt_tag,
    input  logic [COMMIT_WIDTH*XLEN-1:0]           cmt_val,
    input  logic                                   ckpt_req,
    input  logic [LANE_WIDTH-1:0]                  ckpt_lane,
    output ckpt_idx_t                              ckpt_id,
    output logic                                   ckpt_full,
    input  logic                                   ckpt_release,
    input  logic                                   recover,
    input  ckpt_idx_t                              recover_id
);

    logic [XLEN-1:0] val [REG_CNT];
    busy_vec_t       busy;
    tag_tab_t        tag;
    busy_vec_t       clr;
    busy_vec_t       busy_nx;
    tag_tab_t        tag_nx;
    busy_vec_t       ck_busy;
    tag_tab_t        ck_tag;
    busy_vec_t       rec_busy;
    tag_tab_t        rec_tag;
    reg_idx_t        idx;
    reg_idx_t        rd;
    logic            b;
    rob_tag_t        t;
    logic [XLEN-1:0] v;

    // Registers whose current producer retires this cycle.
    always_comb begin
        clr = '0;
        for (int r = 1; r < REG_CNT; r++) begin
            for (int l = 0; l < COMMIT_WIDTH; l++) begin
                if (cmt_valid[l]
                    && cmt_rd[l*REG_CNT_WIDTH +: REG_CNT_WIDTH]
                       == REG_CNT_WIDTH'(r)
                    && cmt_tag[l*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH]
                       == tag[r]) begin
                    clr[r] = 1'b1;
                end
            end
        end
    end

    // Source read with in-group and commit bypass.
    always_comb begin
        rf_val1  = '0;
        rf_val2  = '0;
        rf_busy1 = '0;
        rf_busy2 = '0;
        rf_tag1  = '0;
        rf_tag2  = '0;
        idx      = '0;
        b        = 1'b0;
        t        = '0;
        v        = '0;
        for (int j = 0; j < DEC_WIDTH; j++) begin
            for (int s = 0; s < 2; s++) begin
                idx = (s == 0)
                    ? dec_rs1[j*REG_CNT_WIDTH +: REG_CNT_WIDTH]
                    : dec_rs2[j*REG_CNT_WIDTH +: REG_CNT_WIDTH];
                b = busy[idx] & ~clr[idx];
                t = tag[idx];
                v = val[idx];
                for (int l = 0; l < COMMIT_WIDTH; l++) begin
                    if (cmt_valid[l] && idx != '0
                        && cmt_rd[l*REG_CNT_WIDTH +: REG_CNT_WIDTH]
                           == idx) begin
                        v = cmt_val[l*XLEN +: XLEN];
                    end
                end
                for (int i = 0; i < j; i++) begin
                    if (dec_valid[i] && dec_wr[i]
                        && dec_rd[i*REG_CNT_WIDTH +: REG_CNT_WIDTH]
                           == idx) begin
                        b = 1'b1;
                        t = dec_tag[i*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH];
                    end
                end
                if (idx == '0) begin
                    b = 1'b0;
                end
                if (s == 0) begin
                    rf_val1[j*XLEN +: XLEN]                    = v;
                    rf_busy1[j]                                = b;
                    rf_tag1[j*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH] = t;
                end else begin
                    rf_val2[j*XLEN +: XLEN]                    = v;
                    rf_busy2[j]                                = b;
                    rf_tag2[j*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH] = t;
                end
            end
        end
    end

    // Next table; ck_* is the snapshot image, which only
    // takes renames from slots up to ckpt_lane.
    always_comb begin
        busy_nx = busy & ~clr;
        tag_nx  = tag;
        ck_busy = busy & ~clr;
        ck_tag  = tag;
        rd      = '0;
        if (flush) begin
            busy_nx = '0;
        end else if (recover) begin
            busy_nx = rec_busy;
            tag_nx  = rec_tag;
        end else if (!stall) begin
            for (int i = 0; i < DEC_WIDTH; i++) begin
                rd = dec_rd[i*REG_CNT_WIDTH +: REG_CNT_WIDTH];
                if (dec_valid[i] && dec_wr[i] && rd != '0) begin
                    busy_nx[rd] = 1'b1;
                    tag_nx[rd]  =
                        dec_tag[i*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH];
                    if (i <= int'(ckpt_lane)) begin
                        ck_busy[rd] = 1'b1;
                        ck_tag[rd]  =
                            dec_tag[i*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_CNT; r++) begin
                val[r] <= '0;
            end
            busy <= '0;
            tag  <= '0;
        end else if (rdy) begin
            // Younger lane is written last and wins.
            for (int l = 0; l < COMMIT_WIDTH; l++) begin
                if (cmt_valid[l]
                    && cmt_rd[l*REG_CNT_WIDTH +: REG_CNT_WIDTH] != '0) begin
                    val[cmt_rd[l*REG_CNT_WIDTH +: REG_CNT_WIDTH]] <=
                        cmt_val[l*XLEN +: XLEN];
                end
            end
            busy <= busy_nx;
            tag  <= tag_nx;
        end
    end

    rf_ckpt_bank u_ckpt (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .flush        (flush),
        .stall        (stall),
        .ckpt_req     (ckpt_req),
        .ckpt_release (ckpt_release),
        .recover      (recover),
        .recover_id   (recover_id),
        .cmt_valid    (cmt_valid),
        .cmt_rd       (cmt_rd),
        .cmt_tag      (cmt_tag),
        .snap_busy    (ck_busy),
        .snap_tag     (ck_tag),
        .rec_busy     (rec_busy),
        .rec_tag      (rec_tag),
        .ckpt_id      (ckpt_id),
        .ckpt_full    (ckpt_full)
    );

endmodule

// File: tb/tb_rename_register_file.sv
// Directed bench for rename_register_file.
// Linear stimulus, immediate-assertion checks, one summary line.
module tb_rename_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        flush;
    logic        stall;
    logic [1:0]  dec_valid;
    logic [1:0]  dec_wr;
    logic [9:0]  dec_rd;
    logic [9:0]  dec_rs1;
    logic [9:0]  dec_rs2;
    logic [7:0]  dec_tag;
    logic [63:0] rf_val1;
    logic [63:0] rf_val2;
    logic [1:0]  rf_busy1;
    logic [1:0]  rf_busy2;
    logic [7:0]  rf_tag1;
    logic [7:0]  rf_tag2;
    logic [1:0]  cmt_valid;
    logic [9:0]  cmt_rd;
    logic [7:0]  cmt_tag;
    logic [63:0] cmt_val;
    logic        ckpt_req;
    logic [0:0]  ckpt_lane;
    logic [1:0]  ckpt_id;
    logic        ckpt_full;
    logic        ckpt_release;
    logic        recover;
    logic [1:0]  recover_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rename_register_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .flush        (flush),
        .stall        (stall),
        .dec_valid    (dec_valid),
        .dec_wr       (dec_wr),
        .dec_rd       (dec_rd),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_tag      (dec_tag),
        .rf_val1      (rf_val1),
        .rf_val2      (rf_val2),
        .rf_busy1     (rf_busy1),
        .rf_busy2     (rf_busy2),
        .rf_tag1      (rf_tag1),
        .rf_tag2      (rf_tag2),
        .cmt_valid    (cmt_valid),
        .cmt_rd       (cmt_rd),
        .cmt_tag      (cmt_tag),
        .cmt_val      (cmt_val),
        .ckpt_req     (ckpt_req),
        .ckpt_lane    (ckpt_lane),
        .ckpt_id      (ckpt_id),
        .ckpt_full    (ckpt_full),
        .ckpt_release (ckpt_release),
        .recover      (recover),
        .recover_id   (recover_id)
    );

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Check source s (1 or 2) of slot j; tag checked only when busy.
    task automatic chk_src(input string nm, input int j, input int s,
                           input logic eb, input logic [3:0] et,
                           input logic [31:0] ev);
        logic        gb;
        logic [3:0]  gt;
        logic [31:0] gv;
        gb = (s == 1) ? rf_busy1[j] : rf_busy2[j];
        gt = (s == 1) ? rf_tag1[j*4 +: 4] : rf_tag2[j*4 +: 4];
        gv = (s == 1) ? rf_val1[j*32 +: 32] : rf_val2[j*32 +: 32];
        chk({nm, ".busy"}, 32'(gb), 32'(eb));
        if (eb) chk({nm, ".tag"}, 32'(gt), 32'(et));
        chk({nm, ".val"}, gv, ev);
    endtask

    task automatic idle();
        flush = 0; stall = 0;
        dec_valid = '0; dec_wr = '0; dec_rd = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_tag = '0;
        cmt_valid = '0; cmt_rd = '0; cmt_tag = '0; cmt_val = '0;
        ckpt_req = 0; ckpt_lane = '0; ckpt_release = 0;
        recover = 0; recover_id = '0;
    endtask

    task automatic ren(input int j, input int r, input int t);
        dec_valid[j] = 1'b1;
        dec_wr[j] = 1'b1;
        dec_rd[j*5 +: 5] = 5'(r);
        dec_tag[j*4 +: 4] = 4'(t);
    endtask

    task automatic rd1(input int j, input int r);
        dec_rs1[j*5 +: 5] = 5'(r);
    endtask

    task automatic rd2(input int j, input int r);
        dec_rs2[j*5 +: 5] = 5'(r);
    endtask

    task automatic cmt(input int l, input int r, input int t,
                       input logic [31:0] v);
        cmt_valid[l] = 1'b1;
        cmt_rd[l*5 +: 5] = 5'(r);
        cmt_tag[l*4 +: 4] = 4'(t);
        cmt_val[l*32 +: 32] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst_n = 0;
        rdy = 1;
        idle();
        rd1(0, 5);
        #2;
        chk_src("rst_x5", 0, 1, 0, 0, 32'h0);
        chk("rst_id", 32'(ckpt_id), 0);
        chk("rst_full", 32'(ckpt_full), 0);
        @(negedge clk);
        rst_n = 1;
        step();

        // Commit x5 with same-cycle read, then read back.
        cmt(0, 5, 3, 32'h1234);
        rd1(0, 5);
        #1;
        chk_src("cbyp_x5", 0, 1, 0, 0, 32'h1234);
        step();
        rd1(0, 5);
        #1;
        chk_src("x5", 0, 1, 0, 0, 32'h1234);

        // In-group bypass, then table.
        step();
        ren(0, 7, 2);
        rd1(1, 7);
        #1;
        chk_src("grp_x7", 1, 1, 1, 2, 32'h0);
        step();
        rd1(0, 7);
        rd2(1, 7);
        #1;
        chk_src("tab_x7_s0", 0, 1, 1, 2, 32'h0);
        chk_src("tab_x7_s1", 1, 2, 1, 2, 32'h0);

        // Commit bypass on a busy register.
        step();
        ren(0, 9, 4);
        step();
        cmt(0, 9, 1, 32'h55);
        rd1(0, 9);
        #1;
        chk_src("x9_wrongtag", 0, 1, 1, 4, 32'h55);
        cmt(1, 9, 4, 32'hAA);
        #1;
        chk_src("x9_cmt", 0, 1, 0, 0, 32'hAA);
        step();
        rd1(0, 9);
        #1;
        chk_src("x9_after", 0, 1, 0, 0, 32'hAA);

        // Checkpoint with lane 0: x10 is in, x3 is not.
        step();
        ckpt_req = 1;
        ckpt_lane = 1'b0;
        ren(0, 10, 5);
        ren(1, 3, 6);
        #1;
        chk("ck_id0", 32'(ckpt_id), 0);
        step();
        rd1(0, 3);
        rd2(0, 10);
        #1;
        chk("ck_id1", 32'(ckpt_id), 1);
        chk_src("pre_x3", 0, 1, 1, 6, 32'h0);
        // Recover with a same-cycle commit of x7's producer.
        recover = 1;
        recover_id = 2'd0;
        cmt(0, 7, 2, 32'h77);
        step();
        rd1(0, 3);
        rd2(0, 10);
        rd1(1, 7);
        #1;
        chk_src("rec_x3", 0, 1, 0, 0, 32'h0);
        chk_src("rec_x10", 0, 2, 1, 5, 32'h0);
        chk_src("rec_x7", 1, 1, 0, 0, 32'h77);
        chk("rec_id", 32'(ckpt_id), 0);
        chk("rec_full", 32'(ckpt_full), 0);

        // Fill the FIFO.
        step();
        ren(0, 12, 7);
        step();
        for (int k = 0; k < 4; k++) begin
            ckpt_req = 1;
            #1;
            chk($sformatf("fill_id%0d", k), 32'(ckpt_id), 32'(k));
            step();
        end
        #1;
        chk("full", 32'(ckpt_full), 1);
        // Request while full is dropped; retire x12 meanwhile.
        ckpt_req = 1;
        cmt(0, 12, 7, 32'h12);
        step();
        #1;
        chk("full_drop_id", 32'(ckpt_id), 0);
        chk("full_drop", 32'(ckpt_full), 1);
        ckpt_req = 1;
        ckpt_release = 1;
        step();
        #1;
        chk("relalloc_id", 32'(ckpt_id), 1);
        chk("relalloc_full", 32'(ckpt_full), 1);
        // Snapshot 2 had x12 busy; the commit must have cleared it.
        recover = 1;
        recover_id = 2'd2;
        step();
        rd1(0, 12);
        rd2(0, 10);
        #1;
        chk_src("rec2_x12", 0, 1, 0, 0, 32'h12);
        chk_src("rec2_x10", 0, 2, 1, 5, 32'h0);
        chk("rec2_id", 32'(ckpt_id), 2);
        chk("rec2_full", 32'(ckpt_full), 0);

        // Flush with commit of x4; rename is suppressed.
        step();
        ren(0, 4, 8);
        step();
        flush = 1;
        cmt(0, 4, 0, 32'h7);
        ren(1, 13, 9);
        ckpt_req = 1;
        step();
        rd1(0, 4);
        rd2(0, 13);
        rd1(1, 10);
        #1;
        chk_src("fl_x4", 0, 1, 0, 0, 32'h7);
        chk_src("fl_x13", 0, 2, 0, 0, 32'h0);
        chk_src("fl_x10", 1, 1, 0, 0, 32'h0);
        chk("fl_id", 32'(ckpt_id), 0);
        chk("fl_full", 32'(ckpt_full), 0);

        // Stall blocks rename and allocation.
        stall = 1;
        ren(0, 14, 3);
        ckpt_req = 1;
        step();
        rd1(0, 14);
        #1;
        chk_src("st_x14", 0, 1, 0, 0, 32'h0);
        chk("st_id", 32'(ckpt_id), 0);

        // rdy low holds everything.
        rdy = 0;
        ren(0, 14, 3);
        cmt(0, 15, 0, 32'h99);
        ckpt_req = 1;
        step();
        rdy = 1;
        rd1(0, 14);
        rd2(0, 15);
        #1;
        chk_src("rdy_x14", 0, 1, 0, 0, 32'h0);
        chk_src("rdy_x15", 0, 2, 0, 0, 32'h0);
        chk("rdy_id", 32'(ckpt_id), 0);

        // Asynchronous reset mid-operation.
        ckpt_req = 1;
        step();
        #1;
        chk("pre_rst_id", 32'(ckpt_id), 1);
        #1;
        rst_n = 0;
        rd1(0, 4);
        #1;
        chk("arst_id", 32'(ckpt_id), 0);
        chk_src("arst_x4", 0, 1, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1;
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
